// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide engine.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        MADD  = 3'd2,
        MADDU = 3'd3,
        MSUB  = 3'd4,
        MSUBU = 3'd5,
        DIV   = 3'd6,
        DIVU  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } muldiv_state_t;

    function automatic logic is_signed(muldiv_op_t op);
        return op inside {MULT, MADD, MSUB, DIV};
    endfunction

    function automatic logic is_div(muldiv_op_t op);
        return op inside {DIV, DIVU};
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
// Next-step quotient/remainder are exposed so the final step can be captured directly.
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_nxt_o,
    output logic [WIDTH-1:0] rem_nxt_o
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (diff[WIDTH]) begin
            rem_nxt_o = rem_sh[WIDTH-1:0];
            quo_nxt_o = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt_o = diff[WIDTH-1:0];
            quo_nxt_o = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            quo_q <= quo_nxt_o;
            rem_q <= rem_nxt_o;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply, multiply-accumulate and divide engine with
// flush and a last-divide result cache; result is registered and paired with a done pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] hilo_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int W2      = 2 * WIDTH;
    localparam int MUL_CYC = WIDTH / MUL_STEP;
    localparam int CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t    state_q;
    muldiv_op_t       op_in;
    muldiv_op_t       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [W2-1:0]    hilo_q;
    logic             neg_q, rneg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W2-1:0]    acc_q, mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic             busy_q, done_q;
    logic [W2-1:0]    result_q;

    logic             cache_vld_q;
    muldiv_op_t       cache_op_q;
    logic [WIDTH-1:0] cache_a_q, cache_b_q;
    logic [W2-1:0]    cache_res_q;

    logic             sgn_in, accept, cache_hit, div_load, div_step;
    logic [WIDTH-1:0] mag_a, mag_b, quo_nxt, rem_nxt;
    logic [W2-1:0]    part, acc_d, prod, mul_res, div_res;

    assign op_in     = muldiv_op_t'(op);
    assign sgn_in    = is_signed(op_in);
    assign mag_a     = (sgn_in && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (sgn_in && b[WIDTH-1]) ? -b : b;
    assign accept    = (state_q == ST_IDLE) && start && !flush;
    assign cache_hit = CACHE_EN && cache_vld_q && (op_in == cache_op_q)
                       && (a == cache_a_q) && (b == cache_b_q);
    assign div_load  = accept && is_div(op_in) && (b != '0) && !cache_hit;
    assign div_step  = (state_q == ST_DIV) && !flush;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quo_nxt_o  (quo_nxt),
        .rem_nxt_o  (rem_nxt)
    );

    // The final shift-add is folded into the result so done lands in the FIN cycle.
    always_comb begin
        part = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) part = part + (mcand_q << i);
        end
        acc_d = acc_q + part;
        prod  = neg_q ? -acc_d : acc_d;
        case (op_q)
            MADD, MADDU: mul_res = hilo_q + prod;
            MSUB, MSUBU: mul_res = hilo_q - prod;
            default:     mul_res = prod;
        endcase
    end

    assign div_res = {rneg_q ? -rem_nxt : rem_nxt, neg_q ? -quo_nxt : quo_nxt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= MULT;
            a_q         <= '0;
            b_q         <= '0;
            hilo_q      <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            cache_vld_q <= 1'b0;
            cache_op_q  <= MULT;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_res_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_q   <= op_in;
                        a_q    <= a;
                        b_q    <= b;
                        hilo_q <= hilo_in;
                        neg_q  <= sgn_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_q <= sgn_in && a[WIDTH-1];
                        cnt_q  <= '0;
                        if (is_div(op_in)) begin
                            if (b == '0) begin
                                result_q <= {a, {WIDTH{1'b1}}};
                                done_q   <= 1'b1;
                                state_q  <= ST_FIN;
                            end else if (cache_hit) begin
                                result_q <= cache_res_q;
                                done_q   <= 1'b1;
                                state_q  <= ST_FIN;
                            end else begin
                                busy_q  <= 1'b1;
                                state_q <= ST_DIV;
                            end
                        end else begin
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                            mplier_q <= mag_b;
                            busy_q   <= 1'b1;
                            state_q  <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << MUL_STEP;
                        mplier_q <= mplier_q >> MUL_STEP;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == MUL_LAST) begin
                            result_q <= mul_res;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ST_FIN;
                        end
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == DIV_LAST) begin
                            result_q <= div_res;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ST_FIN;
                            if (CACHE_EN) begin
                                cache_vld_q <= 1'b1;
                                cache_op_q  <= op_q;
                                cache_a_q   <= a_q;
                                cache_b_q   <= b_q;
                                cache_res_q <= div_res;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] hilo_in;
    logic        busy, done;
    logic [63:0] result;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic        c_vld;
    logic [2:0]  c_op;
    logic [31:0] c_a, c_b;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vt[9];

    muldiv_unit #(.WIDTH(32), .MUL_STEP(4), .CACHE_EN(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hilo_in (hilo_in),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] aa,
                                               input logic [31:0] bb, input logic [63:0] hh);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] ua, ub, p;
        sa = {{32{aa[31]}}, aa};
        sb = {{32{bb[31]}}, bb};
        ua = {32'd0, aa};
        ub = {32'd0, bb};
        p  = (o == 3'd0 || o == 3'd2 || o == 3'd4) ? 64'(sa * sb) : ua * ub;
        case (o)
            3'd2, 3'd3: return hh + p;
            3'd4, 3'd5: return hh - p;
            3'd6: begin
                if (bb == 0) return {aa, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            3'd7: begin
                if (bb == 0) return {aa, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return p;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
        if (o < 3'd6) return 9;
        if (bb == 0) return 1;
        if (c_vld && c_op == o && c_a == aa && c_b == bb) return 1;
        return 33;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [63:0] hh, input bit hold,
                         output int lat, output int bcnt, output logic [63:0] res);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb; hilo_in = hh;
        @(posedge clk);
        #1;
        if (hold) begin
            op = DIVU; a = 32'd9; b = 32'd0;
        end else begin
            start = 1'b0;
        end
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        res = result;
        tick();
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [63:0] hh,
                          input logic [63:0] eres, input int elat, input bit hold);
        int lat, bcnt;
        logic [63:0] res;
        issue(o, aa, bb, hh, hold, lat, bcnt, res);
        check({name, "_result"}, res, eres);
        check({name, "_latency"}, 64'(lat), 64'(elat));
        check({name, "_busy_cycles"}, 64'(bcnt), 64'(elat - 1));
        check({name, "_after_done"}, {busy, done}, 64'd0);
        start = 1'b0;
        if (o >= 3'd6 && bb != 0) begin
            c_vld = 1'b1; c_op = o; c_a = aa; c_b = bb;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] prev;
        logic        seen;
        logic [2:0]  o;
        logic [31:0] aa, bb;
        logic [63:0] hh;
        int          sel;

        rst = 1'b1; flush = 1'b0; start = 1'b0;
        op = '0; a = '0; b = '0; hilo_in = '0;
        c_vld = 1'b0; c_op = '0; c_a = '0; c_b = '0;

        vt[0] = '{MULT,  32'hFFFF_FFFE, 32'd3,        64'd0,  64'hFFFF_FFFF_FFFF_FFFA, 9};
        vt[1] = '{DIV,   32'hFFFF_FFF9, 32'd2,        64'd0,  64'hFFFF_FFFF_FFFF_FFFD, 33};
        vt[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,        64'd0,  64'hFFFF_FFFF_FFFF_FFFD, 1};
        vt[3] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 33};
        vt[4] = '{DIVU,  32'd5,         32'd0,        64'd0,  64'h0000_0005_FFFF_FFFF, 1};
        vt[5] = '{MSUB,  32'd3,         32'd5,        64'hA,  64'hFFFF_FFFF_FFFF_FFFB, 9};
        vt[6] = '{MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFE_0000_0002, 9};
        vt[7] = '{MULTU, 32'hFFFF_FFFF, 32'd2,        64'd0,  64'h0000_0001_FFFF_FFFE, 9};
        vt[8] = '{DIV,   32'd7,         32'hFFFF_FFFE, 64'd0, 64'h0000_0001_FFFF_FFFD, 33};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hilo,
                   vt[i].res, vt[i].lat, 1'b0);
        end

        // start held high through busy and done must not launch a second op
        run_op("hold_start", MULTU, 32'd6, 32'd7, 64'd0, 64'd42, 9, 1'b1);

        // flush mid-divide
        prev = result;
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) tick();
        check("busy_before_flush", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        check("flush_result", result, prev);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("flush_no_done", seen, 0);
        run_op("div_after_flush", DIVU, 32'd100, 32'd7, 64'd0, 64'h0000_0002_0000_000E, 33, 1'b0);
        run_op("div_hit_after_flush", DIVU, 32'd100, 32'd7, 64'd0, 64'h0000_0002_0000_000E, 1, 1'b0);

        // flush during the done cycle leaves done intact
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd5; b = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        flush = 1'b1;
        check("fin_flush_done", done, 1);
        check("fin_flush_result", result, 64'h0000_0005_FFFF_FFFF);
        tick();
        flush = 1'b0;
        check("fin_flush_after", {busy, done}, 0);

        // flush and start together in IDLE
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = MULT; a = 32'd3; b = 32'd3;
        tick();
        check("flush_start_busy", busy, 0);
        check("flush_start_done", done, 0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        tick();
        check("flush_start_busy2", busy, 0);

        // asynchronous reset mid-multiply, then cache must be cold
        @(negedge clk);
        start = 1'b1; op = MULT; a = 32'd7; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        tick();
        tick();
        check("busy_mid_mul", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_result", result, 0);
        c_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op("div_after_rst", DIVU, 32'd100, 32'd7, 64'd0, 64'h0000_0002_0000_000E, 33, 1'b0);

        for (int n = 0; n < 40; n++) begin
            o   = 3'($urandom_range(0, 7));
            aa  = $urandom;
            bb  = $urandom;
            hh  = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0) bb = 32'd0;
            else if (sel == 1) bb = 32'($urandom_range(1, 15));
            else if (sel == 2 && c_vld) begin
                o = c_op; aa = c_a; bb = c_b;
            end else if (sel == 3) begin
                aa = 32'h8000_0000; bb = 32'hFFFF_FFFF;
            end else if (sel == 4) begin
                aa = 32'($urandom_range(0, 255)); bb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            run_op($sformatf("rand%0d", n), o, aa, bb, hh,
                   ref_result(o, aa, bb, hh), ref_lat(o, aa, bb), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
